unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Shares a single-port unified instruction/data memory between the core's instruction-fetch port and its load/store port, so that the multicycle core variant can run from one SRAM. Sits between the fetch/LSU logic and the memory macro, and arbitrates between the two requesters round-robin. It keeps exactly one transaction in flight, counts the memory latency, and returns a registered response to whichever requester was granted.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width. Must equal 32, because `be` is 4 bits.
- `MEM_LAT`, default 1: cycles from a sampled `mem_req` to valid `mem_rdata`. Legal range 1..8; any other value is an elaboration error.

Ports (clock and reset first):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  AW  fetch address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid.
- `if_rdata`  out  DW  fetched instruction.
- `d_req`  in  1  data request; held with its payload until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_be`  in  4  store byte enables.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  one-cycle pulse: load data, or store acknowledge.
- `d_rdata`  out  DW  load data; 0 for a store acknowledge.
- `mem_req`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_be`  out  4  memory byte enables.
- `mem_rdata`  in  DW  memory read data.
- `busy`  out  1  a transaction is in flight (state WAIT).

## Operation

**States**
- IDLE: can grant a request.
- WAIT: a transaction is in flight; the latency counter is running.

**Grants in IDLE**
- Grants are combinational. The chosen `*_gnt`, `mem_req` and the muxed `mem_*` payload are driven in the same cycle as the request.
- IDLE → WAIT on any grant. The counter loads `MEM_LAT-1` and `owner` records the granted port.
- Only one `*_gnt` is ever high in a cycle.

**Arbitration**
- A single requester is granted immediately.
- When both request, the port that is not `last_gnt` wins; `last_gnt` updates on every grant.
- `last_gnt` resets to DATA, so fetch wins the first tie.

**WAIT**
- No grants; `mem_req` is 0; the counter decrements every cycle.
- When the counter is 0:
  - `mem_rdata` is captured into `rdata_q`, or 0 is captured if the access is a store.
  - A registered `rvalid` pulse is set for the next cycle to `owner`.
  - The FSM goes to IDLE.

**Response cycle**
- The FSM is already in IDLE, so a new grant may coincide with the `rvalid` pulse (back-to-back operation).
- `*_rdata` holds its last value until the next capture.

**Reset mid-operation**
- An asserted `rst` forces IDLE and drops any pending response; no `rvalid` is issued for the aborted access.
- Requesters must re-issue the access after reset.

**Request stability**
- A requester that drops `req` before `gnt` is not served.
- Changing the payload while a request is pending is legal; the payload sampled at `gnt` is the one used.

## Timing
- **Reset values:** every output is 0; state IDLE; `last_gnt` = DATA; counter 0; `rdata_q` 0.
- **Response latency:** grant in cycle T; `rvalid` in cycle T+MEM_LAT+1.
- **Throughput:** one access every MEM_LAT+1 cycles per port under continuous demand. When both ports request continuously, they alternate and each gets one access every 2·(MEM_LAT+1) cycles.
- **Memory contract:** the memory samples `mem_*` at the end of cycle T, and `mem_rdata` is valid during cycle T+MEM_LAT.
- **Counter width:** $clog2(MEM_LAT) with a minimum of 1 bit. It never wraps, because it is reloaded only on a grant.

## Structure
- **Package `mem_arb_pkg`:**
  - `arb_state_e` {IDLE, WAIT}.
  - `port_id_e` {PORT_IF, PORT_D}.
  - Localparam `BE_W` = 4.
- **Sub-module `arb_rr2`:** a combinational two-way round-robin pick. Inputs are `req[1:0]` and `last`; outputs are one-hot `gnt[1:0]`.
- **Top level:** contains the FSM, counter, owner/`last_gnt` registers, payload mux and response registers.

## Test plan
- **Reset release, single fetch (MEM_LAT=1):** after reset release, `if_req`=1 with `if_addr`=0x10 and memory word 0x00500093 → `if_gnt` is asserted in the request cycle, `mem_addr`=0x10, `mem_we`=0, and `if_rvalid` arrives 2 cycles later with 0x00500093.
- **Simultaneous requests after reset:** `if_req` and `d_req` both held → grants go fetch, data, fetch, data. Each `rvalid` arrives on the port that was granted, and the two ports' `rvalid` pulses alternate.
- **Store (MEM_LAT=3):** `d_we`=1, `d_addr`=0x80, `d_wdata`=0xDEADBEEF, `d_be`=0xF → `mem_we`=1 for one cycle, `d_rvalid` 4 cycles after the grant with `d_rdata`=0, and a subsequent load from 0x80 returns 0xDEADBEEF.
- **Back-to-back fetch (MEM_LAT=2):** continuous `if_req` → `if_gnt` every 3 cycles, each new grant coinciding with the previous `if_rvalid`, and `busy` pattern 0,1,1 repeating.
- **Reset mid-operation:** `rst` pulsed during WAIT of a load → no `d_rvalid` ever appears, all outputs read 0 immediately, and a fresh request is granted on the first cycle after release.
- **Request not held:** `d_req` dropped after one cycle while the arbiter is busy with a fetch → no `d_gnt` and no `mem_req` for that request.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the unified memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM: IDLE can grant, WAIT has one access in flight.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  // Requester identity; the value doubles as the index into req/gnt vectors.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_id_e;

  localparam int BE_W = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module   : arb_rr2
//  Purpose  : Combinational two-way round-robin pick. On a tie the port that
//             was not granted last wins; otherwise the lone requester wins.
//  Revision : 1.0  initial release
// ============================================================================
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_e   last,
  output logic [1:0] gnt
);

  // One-hot pick; req is already one-hot or zero unless both ports ask.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == PORT_D) ? 2'b01 : 2'b10;
    end
  end

endmodule : arb_rr2
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_arbiter
//  Purpose  : Shares one single-port SRAM between instruction fetch and the
//             load/store unit. Round-robin grant, one access in flight,
//             fixed memory latency, registered per-port response.
//  Revision : 1.0  initial release
// ============================================================================
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  // fetch port
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // load/store port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [BE_W-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  // memory macro
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  // status
  output logic            busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  if (DW != 32) begin : g_dw_check
    $error("unified_mem_arbiter: DW must be 32 to match 4-bit byte enables");
  end
  if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_lat_check
    $error("unified_mem_arbiter: MEM_LAT must be in 1..8");
  end

  arb_state_e       state;
  port_id_e         owner;
  port_id_e         last_gnt;
  logic [CNT_W-1:0] cnt;
  logic             store_q;
  logic [1:0]       arb_req;
  logic [1:0]       gnt;

  // Requests are only offered while idle and out of reset, so every
  // combinational output is quiet during reset and while an access is open.
  assign arb_req = (state == IDLE && !rst) ? {d_req, if_req} : 2'b00;

  arb_rr2 u_arb (
    .req  (arb_req),
    .last (last_gnt),
    .gnt  (gnt)
  );

  assign if_gnt = gnt[PORT_IF];
  assign d_gnt  = gnt[PORT_D];
  assign busy   = (state == WAIT);

  // Payload mux: the granted port drives the memory in the grant cycle.
  always_comb begin
    mem_req   = d_gnt | if_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // FSM, latency counter, ownership and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= PORT_IF;
      last_gnt  <= PORT_D;
      cnt       <= '0;
      store_q   <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_gnt || if_gnt) begin
            state    <= WAIT;
            cnt      <= CNT_W'(MEM_LAT - 1);
            owner    <= d_gnt ? PORT_D : PORT_IF;
            last_gnt <= d_gnt ? PORT_D : PORT_IF;
            store_q  <= d_gnt & d_we;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
            if (owner == PORT_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= store_q ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : unified_mem_arbiter
`default_nettype wire
